clk_div_multi: RTL

- Multi-channel programmable clock divider for the digital-clock datapath.
- Each of NUM_CH channels divides the system clock by a runtime-loadable integer and produces:
  - a near-50%-duty square wave (slowclk) for display/blink logic;
  - a one-cycle tick enable for counters that stay in the clk domain.
- Divisor changes are glitch-free and take effect only at a period boundary.
- Per-channel enables and a global synchronous clear allow phase alignment.

---
 rtl/clk_div_multi.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel divides clk by a runtime-loadable integer and produces a
// near-50% square wave (slowclk), a one-cycle tick per period, and reports
// the divisor in effect. New divisors only take effect at a period boundary
// (wrap) or on a global sync_clr, so slowclk never glitches mid-period.

// ---------------------------------------------------------------------------
// One divider channel.
// ---------------------------------------------------------------------------
module clk_div_ch #(
  parameter int CNT_W   = 24,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             slowclk,
  output logic             tick,
  output logic [CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] pdiv, pdiv_nxt;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] div_apply;
  logic             pend, pend_nxt;
  logic             slow_nxt, tick_nxt;
  logic             wrap;

  // Divisors below 2 cannot produce a square wave; clamp them up to 2.
  assign ld_val  = (div_in < MIN_DIV) ? MIN_DIV : div_in;
  // cnt never exceeds D-1 (D changes only when cnt returns to 0), so the
  // increment cannot overflow even for D = 2^CNT_W-1.
  assign cnt_inc = cnt + ONE;
  assign wrap    = (cnt == div_active - ONE);

  // Divisor chosen at a boundary: a same-edge load beats an older pending one.
  assign div_apply = div_load ? ld_val : (pend ? pdiv : div_active);

  // Next-state: sync_clr > hold (en low) > wrap > count.
  always_comb begin
    cnt_nxt  = cnt;
    pdiv_nxt = pdiv;
    div_nxt  = div_active;
    pend_nxt = pend;
    slow_nxt = slowclk;
    tick_nxt = 1'b0;
    if (sync_clr) begin
      cnt_nxt  = '0;
      slow_nxt = 1'b0;
      pend_nxt = 1'b0;
      div_nxt  = div_apply;
    end else if (!en) begin
      if (div_load) begin
        pdiv_nxt = ld_val;
        pend_nxt = 1'b1;
      end
    end else if (wrap) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
      slow_nxt = 1'b0;
      div_nxt  = div_apply;
      pend_nxt = 1'b0;
    end else begin
      cnt_nxt  = cnt_inc;
      slow_nxt = (cnt_inc >= (div_active >> 1));
      if (div_load) begin
        pdiv_nxt = ld_val;
        pend_nxt = 1'b1;
      end
    end
  end

  // Channel state; async reset discards phase and any pending load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      pdiv       <= DIV_RST;
      div_active <= DIV_RST;
      pend       <= 1'b0;
      slowclk    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      pdiv       <= pdiv_nxt;
      div_active <= div_nxt;
      pend       <= pend_nxt;
      slowclk    <= slow_nxt;
      tick       <= tick_nxt;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// Top: NUM_CH independent channels sharing clk, reset and sync_clr.
// ---------------------------------------------------------------------------
module clk_div_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 24,
  parameter int DEF_DIV = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync_clr,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  output logic [NUM_CH-1:0]       slowclk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*CNT_W-1:0] div_active
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en         (en[g]),
      .sync_clr   (sync_clr),
      .div_load   (div_load[g]),
      .div_in     (div_in[g*CNT_W +: CNT_W]),
      .slowclk    (slowclk[g]),
      .tick       (tick[g]),
      .div_active (div_active[g*CNT_W +: CNT_W])
    );
  end

endmodule
